load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the core datapath and data_memory. Turns byte, halfword and word loads/stores into word-wide data_memory accesses.
//  Sub-word stores use a read-modify-write sequence; loads are extracted and sign- or zero-extended.
//  Stalls the core through req_ready while busy. Flags misaligned, reserved-size and out-of-range accesses.
// PARAMETERS
//  MEM_WORDS  10001  number of 32-bit words in data_memory; valid word index range is 0..MEM_WORDS-1
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   asynchronous active-low reset
//  req_valid     in   1   core presents an access
//  req_ready     out  1   block can accept; high only in IDLE
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00=byte, 01=half, 10=word, 11=reserved
//  req_unsigned  in   1   loads: 1=zero-extend, 0=sign-extend
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned
//  rsp_valid     out  1   one-cycle completion pulse
//  rsp_err       out  1   valid with rsp_valid: misaligned, reserved size or out of range
//  rsp_rdata     out  32  extended load data; 0 for stores and errors
//  mem_WE        out  1   to data_memory WE
//  mem_A         out  32  word index = req_addr[31:2]
//  mem_WD        out  32  to data_memory WD
//  mem_RD        in   32  from data_memory; valid the cycle after mem_A is presented
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_WE=0; mem_A=0; mem_WD=0; request registers=0.
//  - mem_* outputs are decoded from the state and captured-request registers only, so mem_WE drops as soon as reset asserts.
//  - Accept: req_valid & req_ready at edge T. addr, size, we, unsigned and wdata are captured at T.
//    Request inputs are ignored at all other times; the core holds its request while req_ready=0.
//  - States: IDLE, RD, LDX, WR, ERR.
//  - Transitions out of IDLE on accept:
//    - error: ERR
//    - word store: WR
//    - otherwise: RD
//  - RD: drive mem_A. Next state is LDX for a load, WR for a sub-word store.
//  - LDX: capture extracted mem_RD into rsp_rdata, then go to IDLE.
//  - WR: assert mem_WE=1 for exactly one cycle with the merged or full word, then go to IDLE.
//  - ERR: no memory strobe; go to IDLE.
//  - rsp_valid/rsp_err/rsp_rdata are registered and pulse on the cycle the FSM re-enters IDLE:
//    - load: T+3
//    - word store: T+2
//    - sub-word store: T+3
//    - error: T+2
//  - A new request may be accepted in the same cycle rsp_valid is high. Back-to-back word stores therefore sustain one every 2 cycles.
//  - Alignment: half requires addr[0]=0; word requires addr[1:0]=00. Size 11 is an error.
//  - Range: addr[31:2] > MEM_WORDS-1 is an error.
//  - Error precedence: size, then alignment, then range. Memory is never touched on an error.
//  - Little-endian lanes:
//    - byte lane = addr[1:0]
//    - half lane = addr[1] (bits [15:0] or [31:16])
//  - Merge: the selected lane of mem_RD is replaced by wdata[7:0] or wdata[15:0]; the other lanes are kept.
//  - Extension: byte/half sign-extend from bit 7/15 unless req_unsigned. Word loads ignore req_unsigned.
//  - Reset mid-RMW (in RD) abandons the access; the memory word is unchanged because the write happens only in WR.
// CONFIGURATION
//  LSU_PERF_CNT_EN defined: adds outputs cnt_loads, cnt_stores, cnt_errs (32 bits each).
//    - Each counts completed accesses of its kind and increments on the rsp_valid cycle.
//    - Counters wrap 0xFFFFFFFF->0 and reset to 0 asynchronously.
//  LSU_PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING (bench instantiates data_memory as the memory model)
//  1. sw addr=0x10 wdata=0xDEADBEEF, then lw 0x10 -> store rsp at T+2 with mem_WE high once; load rsp at T+3 with rsp_rdata=0xDEADBEEF.
//  2. With mem[4]=0x11223344: sb addr=0x11 wdata=0xAA -> mem[4]=0x1122AA44; lb 0x11 -> 0xFFFFFFAA; lbu 0x11 -> 0x000000AA.
//  3. sh addr=0x12 wdata=0x8001 -> mem[4] upper half=0x8001; lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001.
//  4. Error cases, each giving rsp_err=1 at T+2, mem_WE never high and rsp_rdata=0:
//     lw 0x13 (misaligned); sh 0x15 (misaligned); size=11 (reserved); sw to word index 10001 (out of range).
//  5. Assert rst_n=0 while in RD of sb 0x11 -> mem_WE stays 0, mem[4] unchanged, req_ready=1 after release.
//     req_valid pulsed while busy is ignored.
//  6. LSU_PERF_CNT_EN: 3 loads, 2 stores, 1 error -> cnt_loads=3, cnt_stores=2, cnt_errs=1.
//     Forcing cnt_loads to 0xFFFFFFFF and issuing one more load -> cnt_loads=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/half/word core accesses onto word-wide data_memory, RMW for sub-word stores.
// Latency: error and word store respond 2 cycles after issue, loads and sub-word stores respond 3 cycles after issue.
// Backpressure: req_ready is high only in IDLE; the core holds its request while req_ready is low.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (accepted when both high at a rising edge)
//   req_we, req_size, req_unsigned  store flag, size (00 byte, 01 half, 10 word, 11 reserved), zero-extend
//   req_addr, req_wdata             byte address, right-aligned store data
//   rsp_valid, rsp_err, rsp_rdata   one-cycle completion pulse, error flag, extended load data
//   mem_WE, mem_A, mem_WD, mem_RD   data_memory interface (mem_RD valid the cycle after mem_A)
//   cnt_loads/stores/errs           present only when LSU_PERF_CNT_EN is defined
//
// Build option: define LSU_PERF_CNT_EN to add the completed-access counters.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 10001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
`ifdef LSU_PERF_CNT_EN
  output logic [31:0] cnt_loads,
  output logic [31:0] cnt_stores,
  output logic [31:0] cnt_errs,
`endif
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam logic [29:0] MAX_IDX = 30'(MEM_WORDS - 1);
  localparam logic [1:0]  SZ_B    = 2'b00;
  localparam logic [1:0]  SZ_H    = 2'b01;
  localparam logic [1:0]  SZ_W    = 2'b10;
  localparam logic [1:0]  SZ_RSV  = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, LDX, WR, ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        accept;
  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] wr_word;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  // Any one of these is an error; the order only matters for documentation since a single flag results.
  assign req_err = (req_size == SZ_RSV)
                 | ((req_size == SZ_H) & req_addr[0])
                 | ((req_size == SZ_W) & (|req_addr[1:0]))
                 | (req_addr[31:2] > MAX_IDX);

  // Lane extraction from the word returned by memory.
  always_comb begin
    ld_byte = mem_RD[7:0];
    case (addr_q[1:0])
      2'd0: ld_byte = mem_RD[7:0];
      2'd1: ld_byte = mem_RD[15:8];
      2'd2: ld_byte = mem_RD[23:16];
      2'd3: ld_byte = mem_RD[31:24];
      default: ld_byte = mem_RD[7:0];
    endcase
    ld_half = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    case (size_q)
      SZ_B:    ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem_RD;
    endcase
  end

  // Store word: full wdata for word stores, otherwise the old word with one lane replaced.
  // For sub-word stores mem_RD holds the old word during WR because RD presented the same index.
  always_comb begin
    wr_word = mem_RD;
    case (size_q)
      SZ_B: begin
        case (addr_q[1:0])
          2'd0: wr_word[7:0]   = wdata_q[7:0];
          2'd1: wr_word[15:8]  = wdata_q[7:0];
          2'd2: wr_word[23:16] = wdata_q[7:0];
          2'd3: wr_word[31:24] = wdata_q[7:0];
          default: wr_word = mem_RD;
        endcase
      end
      SZ_H: begin
        if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
        else           wr_word[15:0]  = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
  end

  // Memory side depends only on state and captured request, so reset kills the strobe immediately.
  assign mem_WE = (state_q == WR);
  assign mem_A  = {2'b00, addr_q[31:2]};
  assign mem_WD = (state_q == WR) ? wr_word : 32'h0;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (req_err)                         state_d = ERR;
          else if (req_we && req_size == SZ_W) state_d = WR;
          else                                 state_d = RD;
        end
      end
      RD:  state_d = we_q ? WR : LDX;
      LDX: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_ext;
        state_d     = IDLE;
      end
      WR: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      size_q      <= 2'b00;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] cnt_loads_q, cnt_stores_q, cnt_errs_q;

  // Updated on the edge that raises rsp_valid, so the new count is visible alongside the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_loads_q  <= 32'h0;
      cnt_stores_q <= 32'h0;
      cnt_errs_q   <= 32'h0;
    end else begin
      if (state_q == LDX) cnt_loads_q  <= cnt_loads_q + 32'd1;
      if (state_q == WR)  cnt_stores_q <= cnt_stores_q + 32'd1;
      if (state_q == ERR) cnt_errs_q   <= cnt_errs_q + 32'd1;
    end
  end

  assign cnt_loads  = cnt_loads_q;
  assign cnt_stores = cnt_stores_q;
  assign cnt_errs   = cnt_errs_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int MW = 10001;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_WE;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] cnt_loads, cnt_stores, cnt_errs;
`endif

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
`ifdef LSU_PERF_CNT_EN
    .cnt_loads(cnt_loads), .cnt_stores(cnt_stores), .cnt_errs(cnt_errs),
`endif
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory model: synchronous write, registered read.
  logic [31:0] mem [0:MW-1];
  always @(posedge clk) begin
    if (mem_WE && mem_A < 32'(MW)) mem[mem_A[13:0]] <= mem_WD;
    mem_RD <= (mem_A < 32'(MW)) ? mem[mem_A[13:0]] : 32'h0;
  end

  // Reference memory image, updated only through the behavioural model.
  logic [31:0] ref_mem [0:MW-1];

  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output int lat);
    int nbytes, idx, sh;
    logic [31:0] mask, w;
    rd = 32'h0;
    nbytes = 1 << sz;
    err = (sz == 2'd3) || ((addr % nbytes) != 0) || ((addr >> 2) >= 32'(MW));
    if (err || (we && nbytes == 4)) lat = 2; else lat = 3;
    if (!err) begin
      idx  = int'(addr >> 2);
      sh   = 8 * int'(addr % 4);
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
      if (we) ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
      else begin
        w = (ref_mem[idx] >> sh) & mask;
        if (!uns && nbytes < 4 && w[8*nbytes-1]) w = w | ~mask;
        rd = w;
      end
    end
  endtask

  // Driver observations.
  int          o_lat, o_we, o_busy_bad;
  logic        o_err;
  logic [31:0] o_rdata;

  // Called at a negedge with the DUT idle; returns at the negedge on which rsp_valid is high.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit poke);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    o_lat = 1; o_we = 0; o_busy_bad = 0;
    while (!rsp_valid && o_lat < 8) begin
      if (mem_WE) o_we++;
      if (req_ready) o_busy_bad++;
      if (poke) begin
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_addr = 32'($urandom_range(0, 15)) << 2; req_wdata = $urandom;
      end
      @(negedge clk);
      req_valid = 1'b0;
      o_lat++;
    end
    if (mem_WE) o_we++;
    if (!rsp_valid) o_lat = 99;
    o_err = rsp_err;
    o_rdata = rsp_rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_WE, mem_A, mem_WD, req_ready} !== {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: rsp_v=%b err=%b rd=%h we=%b A=%h WD=%h rdy=%b, want all 0 and rdy=1",
               rsp_valid, rsp_err, rsp_rdata, mem_WE, mem_A, mem_WD, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_access();
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    checks++;
    if (o_lat !== 2 || o_we !== 1 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
      errors++;
      $display("FAIL sw_0x10: lat=%0d we=%0d err=%b rd=%h, want lat=2 we=1 err=0 rd=0", o_lat, o_we, o_err, o_rdata);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    checks++;
    if (o_lat !== 3 || o_we !== 0 || o_err !== 1'b0 || o_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_0x10: lat=%0d we=%0d err=%b rd=%h, want lat=3 we=0 err=0 rd=deadbeef", o_lat, o_we, o_err, o_rdata);
    end
  endtask

  task automatic test_byte_access();
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AA, 1'b0);
    checks++;
    if (o_lat !== 3 || o_we !== 1 || o_err !== 1'b0 || mem[4] !== 32'h1122AA44) begin
      errors++;
      $display("FAIL sb_0x11: lat=%0d we=%0d err=%b mem4=%h, want lat=3 we=1 err=0 mem4=1122aa44", o_lat, o_we, o_err, mem[4]);
    end
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0);
    checks++;
    if (o_lat !== 3 || o_err !== 1'b0 || o_rdata !== 32'hFFFFFFAA) begin
      errors++;
      $display("FAIL lb_0x11: lat=%0d err=%b rd=%h, want lat=3 err=0 rd=ffffffaa", o_lat, o_err, o_rdata);
    end
    issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0);
    checks++;
    if (o_lat !== 3 || o_err !== 1'b0 || o_rdata !== 32'h000000AA) begin
      errors++;
      $display("FAIL lbu_0x11: lat=%0d err=%b rd=%h, want lat=3 err=0 rd=000000aa", o_lat, o_err, o_rdata);
    end
  endtask

  task automatic test_half_access();
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF8001, 1'b0);
    checks++;
    if (o_lat !== 3 || o_we !== 1 || mem[4] !== 32'h8001AA44) begin
      errors++;
      $display("FAIL sh_0x12: lat=%0d we=%0d mem4=%h, want lat=3 we=1 mem4=8001aa44", o_lat, o_we, mem[4]);
    end
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
    checks++;
    if (o_lat !== 3 || o_err !== 1'b0 || o_rdata !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh_0x12: lat=%0d err=%b rd=%h, want lat=3 err=0 rd=ffff8001", o_lat, o_err, o_rdata);
    end
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
    checks++;
    if (o_lat !== 3 || o_err !== 1'b0 || o_rdata !== 32'h00008001) begin
      errors++;
      $display("FAIL lhu_0x12: lat=%0d err=%b rd=%h, want lat=3 err=0 rd=00008001", o_lat, o_err, o_rdata);
    end
  endtask

  task automatic test_errors();
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin we = 1'b0; sz = 2'd2; addr = 32'h13; end
        1: begin we = 1'b1; sz = 2'd1; addr = 32'h15; end
        2: begin we = 1'b0; sz = 2'd3; addr = 32'h10; end
        3: begin we = 1'b1; sz = 2'd2; addr = 32'(MW) << 2; end
        default: begin we = 1'b1; sz = 2'd3; addr = 32'h15; end
      endcase
      issue(we, sz, 1'b0, addr, 32'hCAFEF00D, 1'b0);
      checks++;
      if (o_lat !== 2 || o_we !== 0 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
        errors++;
        $display("FAIL err_case%0d: lat=%0d we=%0d err=%b rd=%h, want lat=2 we=0 err=1 rd=0", i, o_lat, o_we, o_err, o_rdata);
      end
    end
    // Last valid word index is not an error.
    issue(1'b1, 2'd2, 1'b0, 32'(MW - 1) << 2, 32'h5A5A1234, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'(MW - 1) << 2, 32'h0, 1'b0);
    checks++;
    if (o_lat !== 3 || o_err !== 1'b0 || o_rdata !== 32'h5A5A1234) begin
      errors++;
      $display("FAIL last_word: lat=%0d err=%b rd=%h, want lat=3 err=0 rd=5a5a1234", o_lat, o_err, o_rdata);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int we_seen;
    we_seen = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_WE !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_rd: we=%b rdy=%b rsp_v=%b, want we=0 rdy=1 rsp_v=0", mem_WE, req_ready, rsp_valid);
    end
    repeat (2) begin @(negedge clk); if (mem_WE) we_seen++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (mem_WE) we_seen++; end
    checks++;
    if (we_seen !== 0 || mem[4] !== 32'h8001AA44 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_rmw_after: we_seen=%0d mem4=%h rdy=%b, want 0 8001aa44 1", we_seen, mem[4], req_ready);
    end
  endtask

  task automatic test_busy_ignore();
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h0BADF00D, 1'b1);
    checks++;
    if (o_busy_bad !== 0 || o_lat !== 2) begin
      errors++;
      $display("FAIL busy_sw: ready_high_while_busy=%0d lat=%0d, want 0 and 2", o_busy_bad, o_lat);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    checks++;
    if (o_busy_bad !== 0 || o_rdata !== 32'h0BADF00D || o_we !== 0) begin
      errors++;
      $display("FAIL busy_lw: ready_high_while_busy=%0d rd=%h we=%0d, want 0 0badf00d 0", o_busy_bad, o_rdata, o_we);
    end
  endtask

  task automatic test_back_to_back_random();
    logic        we, uns, e_err;
    logic [1:0]  sz;
    logic [31:0] addr, wd, e_rd;
    int          e_lat, sel, nfail;
    nfail = 0;
    // Prefill a window and the top words back-to-back so the model knows every word it will touch.
    for (int w = 0; w < 21; w++) begin
      addr = (w < 16) ? 32'(w) << 2 : 32'(MW - 21 + w) << 2;
      wd = $urandom;
      model(1'b1, 2'd2, 1'b0, addr, wd, e_err, e_rd, e_lat);
      issue(1'b1, 2'd2, 1'b0, addr, wd, 1'b0);
      checks++;
      if (o_lat !== e_lat || o_we !== 1 || o_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_sw[%0d]: lat=%0d we=%0d err=%b, want lat=%0d we=1 err=0", w, o_lat, o_we, o_err, e_lat);
      end
    end
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom_range(0, 3));
      wd = $urandom; sel = $urandom_range(0, 9);
      if (sel < 8)       addr = 32'($urandom_range(0, 63));
      else if (sel == 8) addr = (32'(MW - 5) << 2) + 32'($urandom_range(0, 23));
      else               addr = $urandom;
      model(we, sz, uns, addr, wd, e_err, e_rd, e_lat);
      issue(we, sz, uns, addr, wd, ($urandom_range(0, 7) == 0));
      checks++;
      if (o_lat !== e_lat || o_we !== int'(we && !e_err) || o_err !== e_err ||
          o_rdata !== e_rd || o_busy_bad !== 0) begin
        errors++;
        if (nfail < 10)
          $display("FAIL rand[%0d] we=%b sz=%0d uns=%b a=%h: lat=%0d wecnt=%0d err=%b rd=%h busy_rdy=%0d, want lat=%0d err=%b rd=%h",
                   n, we, sz, uns, addr, o_lat, o_we, o_err, o_rdata, o_busy_bad, e_lat, e_err, e_rd);
        nfail++;
      end
    end
  endtask

`ifdef LSU_PERF_CNT_EN
  task automatic test_perf_counters();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt_loads !== 32'h0 || cnt_stores !== 32'h0 || cnt_errs !== 32'h0) begin
      errors++;
      $display("FAIL cnt_reset: %0d %0d %0d, want 0 0 0", cnt_loads, cnt_stores, cnt_errs);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h01020304, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h77, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
    checks++;
    if (cnt_loads !== 32'd3 || cnt_stores !== 32'd2 || cnt_errs !== 32'd1) begin
      errors++;
      $display("FAIL cnt_mix: loads=%0d stores=%0d errs=%0d, want 3 2 1", cnt_loads, cnt_stores, cnt_errs);
    end
    force dut.cnt_loads_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_loads_q;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    checks++;
    if (cnt_loads !== 32'h0 || cnt_stores !== 32'd2) begin
      errors++;
      $display("FAIL cnt_wrap: loads=%h stores=%0d, want 0 and 2", cnt_loads, cnt_stores);
    end
  endtask
`endif

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_word_access();
    test_byte_access();
    test_half_access();
    test_errors();
    test_reset_mid_rmw();
    test_busy_ignore();
    test_back_to_back_random();
`ifdef LSU_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
